// File: rtl/bp_update_scheduler.sv
// Branch-predictor update scheduler: two resolved-branch lanes feed a small FIFO,
// and the FIFO drains into a single-port predictor update stream. BP_SCHED_STATS_EN adds the statistics counters.
module bp_update_scheduler #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            res0_valid,
   input  logic [PC_W-1:0] res0_pc,
   input  logic            res0_taken,
   input  logic            res0_pred,
   input  logic            res1_valid,
   input  logic [PC_W-1:0] res1_pc,
   input  logic            res1_taken,
   input  logic            res1_pred,
   input  logic            upd_hold,
   output logic            res_ready,
   output logic            upd_en,
   output logic [PC_W-1:0] upd_pc,
   output logic            upd_taken,
   output logic            mispredict,
`ifdef BP_SCHED_STATS_EN
   output logic [31:0]     stat_branches,
   output logic [31:0]     stat_mispred,
`endif
   output logic            overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [AW-1:0]   r_wr;
   logic [AW-1:0]   r_rd;
   logic [AW-1:0]   w_wr1_addr;
   logic [CW-1:0]   r_count;
   logic [CW-1:0]   w_count_next;
   logic [CW-1:0]   w_free;
   logic [PC_W:0]   r_mem [DEPTH];

   logic            r_upd_en;
   logic [PC_W-1:0] r_upd_pc;
   logic            r_upd_taken;
   logic            r_mispredict;
   logic            r_overflow;

   logic            w_pop;
   logic            w_mis0;
   logic            w_mis1;
   logic            w_acc1;
   logic            w_push0;
   logic            w_push1;
   logic            w_drop;
   logic            w_mis_next;

   // A mispredicted older branch makes the younger lane wrong-path: discarded, not dropped.
   assign w_mis0 = res0_taken ^ res0_pred;
   assign w_mis1 = res1_taken ^ res1_pred;
   assign w_acc1 = res1_valid && !(res0_valid && w_mis0);

   // Slots freed by this cycle's pop are usable by this cycle's pushes.
   assign w_free  = CW'(DEPTH) - r_count + CW'(w_pop);
   assign w_push0 = res0_valid && (w_free != '0);
   assign w_push1 = w_acc1 && (w_push0 ? (w_free >= CW'(2)) : (w_free != '0));
   assign w_drop  = (res0_valid && !w_push0) || (w_acc1 && !w_push1);
   assign w_mis_next = (w_push0 && w_mis0) || (w_push1 && w_mis1);

   assign w_count_next = r_count + CW'(w_push0) + CW'(w_push1) - CW'(w_pop);
   assign w_wr1_addr   = w_push0 ? (r_wr + AW'(1)) : r_wr;

   assign res_ready  = (r_count <= CW'(DEPTH - 2));
   assign upd_en     = r_upd_en;
   assign upd_pc     = r_upd_pc;
   assign upd_taken  = r_upd_taken;
   assign mispredict = r_mispredict;
   assign overflow   = r_overflow;

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next state, from the post-update occupancy and the current hold request
   always_comb begin
      w_state_next = S_IDLE;
      if (w_count_next != '0) begin
         w_state_next = upd_hold ? S_HOLD : S_ISSUE;
      end
   end

   // FSM outputs: the hold input also blocks a pop the same cycle it rises
   always_comb begin
      w_pop = 1'b0;
      if (r_state == S_ISSUE && !upd_hold) begin
         w_pop = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         r_wr    <= r_wr + AW'(w_push0) + AW'(w_push1);
         r_rd    <= r_rd + AW'(w_pop);
         r_count <= w_count_next;
      end
   end

   // Queue storage holds {taken, pc}; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (w_push0) begin
         r_mem[r_wr] <= {res0_taken, res0_pc};
      end
      if (w_push1) begin
         r_mem[w_wr1_addr] <= {res1_taken, res1_pc};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_upd_en     <= 1'b0;
         r_upd_pc     <= '0;
         r_upd_taken  <= 1'b0;
         r_mispredict <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_upd_en     <= w_pop;
         r_mispredict <= w_mis_next;
         if (w_pop) begin
            {r_upd_taken, r_upd_pc} <= r_mem[r_rd];
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

`ifdef BP_SCHED_STATS_EN
   logic [31:0] r_stat_branches;
   logic [31:0] r_stat_mispred;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stat_branches <= '0;
         r_stat_mispred  <= '0;
      end else begin
         r_stat_branches <= r_stat_branches + 32'(w_push0) + 32'(w_push1);
         if (w_mis_next) begin
            r_stat_mispred <= r_stat_mispred + 32'd1;
         end
      end
   end

   assign stat_branches = r_stat_branches;
   assign stat_mispred  = r_stat_mispred;
`endif

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Directed bench for bp_update_scheduler (DEPTH=4, PC_W=32) with hand-computed expectations.
module tb_bp_update_scheduler;

   logic        clk;
   logic        rst;
   logic        res0_valid, res0_taken, res0_pred;
   logic [31:0] res0_pc;
   logic        res1_valid, res1_taken, res1_pred;
   logic [31:0] res1_pc;
   logic        upd_hold;
   logic        res_ready, upd_en, upd_taken, mispredict, overflow;
   logic [31:0] upd_pc;
`ifdef BP_SCHED_STATS_EN
   logic [31:0] stat_branches, stat_mispred;
`endif

   int checks = 0;
   int errors = 0;

   bp_update_scheduler #(.DEPTH(4), .PC_W(32)) dut (
      .clk(clk), .rst(rst),
      .res0_valid(res0_valid), .res0_pc(res0_pc), .res0_taken(res0_taken), .res0_pred(res0_pred),
      .res1_valid(res1_valid), .res1_pc(res1_pc), .res1_taken(res1_taken), .res1_pred(res1_pred),
      .upd_hold(upd_hold), .res_ready(res_ready),
      .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .mispredict(mispredict),
`ifdef BP_SCHED_STATS_EN
      .stat_branches(stat_branches), .stat_mispred(stat_mispred),
`endif
      .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic lane0(input logic v, input logic [31:0] pc, input logic t, input logic p);
      res0_valid = v; res0_pc = pc; res0_taken = t; res0_pred = p;
   endtask

   task automatic lane1(input logic v, input logic [31:0] pc, input logic t, input logic p);
      res1_valid = v; res1_pc = pc; res1_taken = t; res1_pred = p;
   endtask

   initial begin
      rst = 1'b1;
      upd_hold = 1'b0;
      lane0(1'b0, 32'h0, 1'b0, 1'b0);
      lane1(1'b0, 32'h0, 1'b0, 1'b0);
      #1 rst = 1'b0;
      #1;
      // Asynchronous reset, before any clock edge
      chk("rst_upd_en", upd_en, 0);
      chk("rst_upd_pc", upd_pc, 0);
      chk("rst_upd_taken", upd_taken, 0);
      chk("rst_mispredict", mispredict, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_res_ready", res_ready, 1);
      step();
      step();

      // Single correctly predicted branch into an empty queue
      rst = 1'b1;
      lane0(1'b1, 32'h40, 1'b1, 1'b1);
      step();
      lane0(1'b0, 32'h0, 1'b0, 1'b0);
      chk("t1_edge1_upd_en", upd_en, 0);
      chk("t1_edge1_mispredict", mispredict, 0);
      step();
      chk("t1_edge2_upd_en", upd_en, 1);
      chk("t1_edge2_upd_pc", upd_pc, 32'h40);
      chk("t1_edge2_upd_taken", upd_taken, 1);
      chk("t1_edge2_mispredict", mispredict, 0);
      step();
      chk("t1_after_upd_en", upd_en, 0);
      chk("t1_after_upd_pc_hold", upd_pc, 32'h40);

      // Two lanes in one cycle issue in program order
      lane0(1'b1, 32'h100, 1'b0, 1'b0);
      lane1(1'b1, 32'h104, 1'b1, 1'b1);
      step();
      lane0(1'b0, 32'h0, 1'b0, 1'b0);
      lane1(1'b0, 32'h0, 1'b0, 1'b0);
      chk("t2_push_upd_en", upd_en, 0);
      chk("t2_count2_res_ready", res_ready, 1);
      step();
      chk("t2_first_upd_en", upd_en, 1);
      chk("t2_first_upd_pc", upd_pc, 32'h100);
      chk("t2_first_upd_taken", upd_taken, 0);
      step();
      chk("t2_second_upd_en", upd_en, 1);
      chk("t2_second_upd_pc", upd_pc, 32'h104);
      chk("t2_second_upd_taken", upd_taken, 1);
      step();
      chk("t2_drained_upd_en", upd_en, 0);

      // Lane-0 mispredict squashes lane 1
      lane0(1'b1, 32'h200, 1'b1, 1'b0);
      lane1(1'b1, 32'h204, 1'b1, 1'b1);
      step();
      lane0(1'b0, 32'h0, 1'b0, 1'b0);
      lane1(1'b0, 32'h0, 1'b0, 1'b0);
      chk("t3_mispredict_pulse", mispredict, 1);
      chk("t3_overflow", overflow, 0);
      step();
      chk("t3_mispredict_clear", mispredict, 0);
      chk("t3_upd_en", upd_en, 1);
      chk("t3_upd_pc", upd_pc, 32'h200);
      chk("t3_upd_taken", upd_taken, 1);
      step();
      chk("t3_no_wrongpath_upd", upd_en, 0);
      chk("t3_upd_pc_hold", upd_pc, 32'h200);
      chk("t3_overflow_after", overflow, 0);

      // Fill under hold, overflow the queue, then drain
      upd_hold = 1'b1;
      lane0(1'b1, 32'h300, 1'b1, 1'b1);
      lane1(1'b1, 32'h304, 1'b0, 1'b0);
      step();
      chk("t4_c2_res_ready", res_ready, 1);
      chk("t4_c2_overflow", overflow, 0);
      lane0(1'b1, 32'h308, 1'b1, 1'b1);
      lane1(1'b1, 32'h30C, 1'b0, 1'b0);
      step();
      chk("t4_c4_res_ready", res_ready, 0);
      chk("t4_c4_overflow", overflow, 0);
      lane0(1'b1, 32'h310, 1'b1, 1'b1);
      lane1(1'b1, 32'h314, 1'b1, 1'b1);
      step();
      lane0(1'b0, 32'h0, 1'b0, 1'b0);
      lane1(1'b0, 32'h0, 1'b0, 1'b0);
      chk("t4_full_overflow", overflow, 1);
      chk("t4_full_res_ready", res_ready, 0);
      chk("t4_hold_upd_en", upd_en, 0);
      step();
      chk("t4_hold2_upd_en", upd_en, 0);
      upd_hold = 1'b0;
      step();
      chk("t4_release_upd_en", upd_en, 0);
      step();
      chk("t4_d0_upd_en", upd_en, 1);
      chk("t4_d0_upd_pc", upd_pc, 32'h300);
      chk("t4_d0_upd_taken", upd_taken, 1);
      step();
      chk("t4_d1_upd_pc", upd_pc, 32'h304);
      chk("t4_d1_upd_taken", upd_taken, 0);
      step();
      chk("t4_d2_upd_pc", upd_pc, 32'h308);
      step();
      chk("t4_d3_upd_en", upd_en, 1);
      chk("t4_d3_upd_pc", upd_pc, 32'h30C);
      step();
      chk("t4_d4_upd_en", upd_en, 0);
      chk("t4_overflow_sticky", overflow, 1);
      chk("t4_mispredict", mispredict, 0);
`ifdef BP_SCHED_STATS_EN
      chk("stat_branches", stat_branches, 8);
      chk("stat_mispred", stat_mispred, 1);
`endif

      // Three queued entries discarded by a reset pulse
      upd_hold = 1'b1;
      lane0(1'b1, 32'h400, 1'b1, 1'b1);
      lane1(1'b1, 32'h404, 1'b1, 1'b1);
      step();
      chk("t5_c2_res_ready", res_ready, 1);
      lane0(1'b1, 32'h408, 1'b1, 1'b1);
      lane1(1'b0, 32'h0, 1'b0, 1'b0);
      step();
      lane0(1'b0, 32'h0, 1'b0, 1'b0);
      chk("t5_c3_res_ready", res_ready, 0);
      rst = 1'b0;
      #1;
      chk("t5_rst_upd_en", upd_en, 0);
      chk("t5_rst_upd_pc", upd_pc, 0);
      chk("t5_rst_upd_taken", upd_taken, 0);
      chk("t5_rst_mispredict", mispredict, 0);
      chk("t5_rst_overflow", overflow, 0);
      chk("t5_rst_res_ready", res_ready, 1);
      step();
      rst = 1'b1;
      upd_hold = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("t5_no_upd_%0d", i), upd_en, 0);
      end
      chk("t5_res_ready_end", res_ready, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
